// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: RISC-V opcodes, branch funct3
// codes, 2-bit counter states and the saturating counter step.
package branch_pkg;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  // Step a 2-bit counter toward the observed direction, sticking at the ends.
  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken && (cnt != CNT_STRONG_T)) nxt = cnt + 2'd1;
    else if (!taken && (cnt != CNT_STRONG_NT)) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Decodes a resolving instruction: actual direction from the ALU flags, and
// whether it is a conditional branch or an unconditional jump.
module branch_cond
  import branch_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zf_i,
  input  logic       cf_i,
  input  logic       vf_i,
  input  logic       sf_i,
  output logic       taken_o,
  output logic       is_cond_o,
  output logic       is_jump_o
);

  always_comb begin
    taken_o   = 1'b0;
    is_cond_o = 1'b0;
    is_jump_o = 1'b0;
    if (opcode_i == OPC_JAL || opcode_i == OPC_JALR) begin
      taken_o   = 1'b1;
      is_jump_o = 1'b1;
    end else if (opcode_i == OPC_BRANCH) begin
      // funct3 010/011 are reserved: not taken and not a conditional branch.
      is_cond_o = 1'b1;
      case (funct3_i)
        F3_BEQ:  taken_o = zf_i;
        F3_BNE:  taken_o = ~zf_i;
        F3_BLT:  taken_o = sf_i ^ vf_i;
        F3_BGE:  taken_o = ~(sf_i ^ vf_i);
        F3_BLTU: taken_o = cf_i;
        F3_BGEU: taken_o = ~cf_i;
        default: is_cond_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by
// PC word address, with resolution-time update and branch/mispredict stats.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int XLEN    = 32,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pred_pc,
  output logic             pred_taken,
  input  logic             res_valid,
  input  logic [XLEN-1:0]  res_pc,
  input  logic [6:0]       res_opcode,
  input  logic [2:0]       res_funct3,
  input  logic             zf,
  input  logic             cf,
  input  logic             vf,
  input  logic             sf,
  input  logic             res_pred_taken,
  output logic             res_taken,
  output logic             mispredict,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [1:0]       bht_q [ENTRIES];
  logic [IDX_W-1:0] pred_idx;
  logic [IDX_W-1:0] res_idx;
  logic             is_cond;
  logic             is_jump;
  logic             armed_q;
  logic             res_live;
  logic             cond_upd;
  logic             cond_miss;
  logic             mispredict_d;
  logic             mispredict_q;
  logic [CNT_W-1:0] branch_cnt_d,     branch_cnt_q;
  logic [CNT_W-1:0] mispredict_cnt_d, mispredict_cnt_q;
  logic             unused_pc_bits;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign res_idx  = res_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{pred_pc[XLEN-1:IDX_W+2], pred_pc[1:0],
                            res_pc[XLEN-1:IDX_W+2], res_pc[1:0]};

  branch_cond u_cond (
    .opcode_i  (res_opcode),
    .funct3_i  (res_funct3),
    .zf_i      (zf),
    .cf_i      (cf),
    .vf_i      (vf),
    .sf_i      (sf),
    .taken_o   (res_taken),
    .is_cond_o (is_cond),
    .is_jump_o (is_jump)
  );

  // No bypass: a same-cycle resolution to this entry shows up next cycle.
  assign pred_taken = bht_q[pred_idx][1];

  // armed_q stays low for the first edge after reset release so a resolution
  // presented in that cycle is dropped.
  assign res_live  = res_valid & armed_q;
  assign cond_upd  = res_live & is_cond;
  assign cond_miss = cond_upd & (res_taken != res_pred_taken);

  always_comb begin
    mispredict_d     = cond_miss | (res_live & is_jump & ~res_pred_taken);
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (cond_upd && !(&branch_cnt_q)) branch_cnt_d = branch_cnt_q + 1'b1;
    if (cond_miss && !(&mispredict_cnt_q)) mispredict_cnt_d = mispredict_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) bht_q[i] <= CNT_WEAK_NT;
    end else if (cond_upd) begin
      bht_q[res_idx] <= sat_update(bht_q[res_idx], res_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q          <= 1'b0;
      mispredict_q     <= 1'b0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      armed_q          <= 1'b1;
      mispredict_q     <= mispredict_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign mispredict     = mispredict_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL provide parameter ENTRIES, default 64, meaning the number of branch history table (BHT) entries; power of 2, 4..1024.
REQ-002 SHALL provide parameter XLEN, default 32, meaning the PC width.
REQ-003 SHALL provide parameter CNT_W, default 32, meaning the width of each statistics counter.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL provide port clk, input, 1, meaning the sole clock; all state updates on its rising edge.
REQ-006 SHALL provide port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL provide port pred_pc, input, XLEN, meaning the fetch PC to predict.
REQ-008 SHALL provide port pred_taken, output, 1, meaning the combinational prediction for pred_pc.
REQ-009 SHALL provide port res_valid, input, 1, meaning a resolution request is presented this cycle.
REQ-010 SHALL provide port res_pc, input, XLEN, meaning the PC of the resolving instruction.
REQ-011 SHALL provide port res_opcode, input, 7, meaning the instruction opcode field.
REQ-012 SHALL provide port res_funct3, input, 3, meaning the branch condition code.
REQ-013 SHALL provide ports zf, cf, vf and sf, each input, 1, meaning the ALU flags of the compare.
REQ-014 SHALL provide port res_pred_taken, input, 1, meaning the prediction originally made for res_pc.
REQ-015 SHALL provide port res_taken, output, 1, meaning the combinational actual-direction result.
REQ-016 SHALL provide port mispredict, output, 1, meaning a registered single-cycle pulse.
REQ-017 SHALL provide port branch_cnt, output, CNT_W, meaning the count of resolved conditional branches.
REQ-018 SHALL provide port mispredict_cnt, output, CNT_W, meaning the count of mispredicted conditional branches.

Function
REQ-019 SHALL form the index as pc[IDX_W+1:2], where IDX_W = log2(ENTRIES).
REQ-020 SHALL hold a 2-bit saturating counter per entry: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-021 SHALL drive pred_taken as the MSB of the indexed counter, with zero-cycle latency.
REQ-022 SHALL drive res_taken = 1 for JAL/JALR opcodes.
REQ-023 SHALL evaluate res_taken for branch opcodes as: BEQ zf; BNE !zf; BLT sf!=vf; BGE sf==vf; BLTU cf; BGEU !cf.
REQ-024 SHALL drive res_taken = 0 for funct3 010/011 and for all other opcodes.
REQ-025 SHALL classify as a "conditional branch" only a branch opcode with a legal funct3 and res_valid=1.
REQ-026 SHALL, on a conditional branch, update the indexed counter at the next edge: +1 if taken, -1 if not, saturating at 11 and 00.
REQ-027 SHALL NOT update any BHT entry or statistics counter for JAL/JALR, illegal funct3, non-branch opcodes or res_valid=0.
REQ-028 SHALL assert mispredict for exactly one cycle, on the cycle after a conditional branch with res_taken != res_pred_taken.
REQ-029 SHALL assert mispredict for one cycle after a JAL/JALR with res_pred_taken=0; no BHT update in that case.
REQ-030 SHALL increment branch_cnt once per conditional branch, saturating at all-ones.
REQ-031 SHALL increment mispredict_cnt once per REQ-028 event, saturating at all-ones; JAL/JALR mispredicts SHALL NOT be counted.
REQ-032 SHALL, when pred_pc and res_pc index the same entry in one cycle, return the pre-update value (no bypass).
REQ-033 SHALL apply back-to-back resolutions to one entry each cycle, with each update seeing the prior update's result.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously set all BHT entries to 01, mispredict to 0, branch_cnt to 0 and mispredict_cnt to 0.
REQ-035 SHALL discard any resolution presented in the cycle in which rst_n deasserts, with no update and no pulse.
REQ-036 SHALL, on reset asserted while mispredict is high, drop mispredict immediately.

Structure
REQ-037 SHALL place opcode constants (JAL, JALR, BRANCH), funct3 codes (BEQ..BGEU) and the counter-state encodings in shared package branch_pkg.
REQ-038 SHALL contain one combinational sub-module, branch_cond, implementing REQ-022..REQ-024.

Verification
REQ-039 SHALL cover: reset, then pred_pc=0x100 -> pred_taken=0; entry 0x100 reads 01.
REQ-040 SHALL cover: BEQ at res_pc=0x100, zf=1, res_pred_taken=0 -> res_taken=1; next cycle mispredict=1, entry=10, branch_cnt=1, mispredict_cnt=1.
REQ-041 SHALL cover: three taken BEQs at 0x100 back-to-back -> entry saturates at 11; a fourth leaves it at 11.
REQ-042 SHALL cover: JAL with res_pred_taken=0 -> mispredict pulse; branch_cnt and all BHT entries unchanged.
REQ-043 SHALL cover: same-cycle predict/resolve at 0x200 (entry 01, taken) -> pred_taken=0 that cycle, 1 the next.
REQ-044 SHALL cover: funct3=010 with res_valid=1, and CNT_W=4 with 20 branches -> no update for 010; branch_cnt=15 (saturated).
